// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM encoding and port indices.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick with lock: while locked only the last owner may win.
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       locked,
  output logic       valid,
  output logic       winner
);

  logic [1:0] eligible;

  always_comb begin
    eligible = locked ? (req & port_onehot(last_owner)) : req;
    valid    = |eligible;
    // On a tie the port that did not win last time goes next.
    if (&eligible) winner = ~last_owner;
    else           winner = eligible[PORT_DMA];
  end

endmodule

// File: rtl/sram.sv
// Single-port synchronous SRAM; reads and writes happen on the falling clock edge.
module sram #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     mem_rd_en,
  input  logic                     mem_wr_en,
  input  logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic [DATA_WIDTH-1:0]    mem_rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(negedge clk) begin
    if (mem_wr_en) mem[addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[addr];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between CPU (port 0) and DMA (port 1): gnt one cycle after the
// sampled request, read data one cycle after gnt, at most one access per two cycles.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [1:0]               lock,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic [1:0]               gnt,
  output logic [1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data
);

  state_t                   state;
  logic                     last_owner;
  logic                     locked;
  logic                     cur_we;
  logic                     pick_valid;
  logic                     pick_winner;
  logic                     sel_we;
  logic                     sel_lock;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .locked     (locked),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_we    = we[pick_winner];
    sel_lock  = lock[pick_winner];
    sel_addr  = pick_winner ? addr1 : addr0;
    sel_wdata = pick_winner ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      locked      <= 1'b0;
      last_owner  <= PORT_DMA;
      cur_we      <= 1'b0;
    end else begin
      gnt       <= '0;
      rvalid    <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        ACCESS: begin
          // The SRAM has already produced read data on this cycle's falling edge.
          if (!cur_we) begin
            rdata  <= mem_rd_data;
            rvalid <= port_onehot(last_owner);
          end
          state <= DONE;
        end
        default: begin
          if (pick_valid) begin
            state      <= ACCESS;
            last_owner <= pick_winner;
            locked     <= sel_lock;
            cur_we     <= sel_we;
            gnt        <= port_onehot(pick_winner);
            mem_addr   <= sel_addr;
            if (sel_we) mem_wr_data <= sel_wdata;
            mem_rd_en  <= ~sel_we;
            mem_wr_en  <= sel_we;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // A requester must keep req high until the cycle its gnt is shown.
  for (genvar i = 0; i < 2; i++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (reset)
      (req[i] && !gnt[i]) |=> req[i]);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with the real sram: expectations are queued by
// the stimulus and consumed by a monitor whenever gnt or rvalid is seen.
module tb_sram_arbiter;

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } gexp_t;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
  } rexp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req, we, lock;
  logic [15:0] addr0, addr1, mem_addr;
  logic [7:0]  wdata0, wdata1, rdata, mem_wr_data, mem_rd_data;
  logic [1:0]  gnt, rvalid;
  logic        mem_rd_en, mem_wr_en;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    lat;
  int    n0;
  gexp_t gq[$];
  rexp_t rq[$];
  int    gnt_cycles[$];
  gexp_t ge;
  rexp_t re;
  logic [1:0] prev_gnt = 2'b00;
  logic       prev_rd = 1'b0;

  sram_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  sram #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) u_sram (
    .clk(clk), .addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] g, input logic w, input logic [15:0] a, input logic [7:0] d);
    gexp_t e;
    e.gnt = g; e.we = w; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] p, input logic [7:0] d);
    rexp_t e;
    e.port = p; e.data = d;
    rq.push_back(e);
  endtask

  // Raise a request, hold it through its gnt cycle, drop it at the edge ending gnt.
  task automatic issue(input logic p, input logic w, input logic lk, input logic [15:0] a,
                       input logic [7:0] d, output int l);
    l = 0;
    if (p) begin addr1 = a; wdata1 = d; end
    else   begin addr0 = a; wdata0 = d; end
    we[p] = w; lock[p] = lk; req[p] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (gnt[p]) begin l = i; break; end
    end
    if (l == 0) begin
      checks++; errors++;
      $display("FAIL issue_timeout: port %0d got no gnt in 40 cycles, gnt required", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    check({tag, "_rdata"}, 32'(rdata), 32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'h0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'h0);
    check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'h0);
  endtask

  task automatic reset_pulse();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    check("enable_iff_gnt", 32'(mem_rd_en | mem_wr_en), 32'(gnt != 2'b00));
    if (gnt != 2'b00) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_unexpected: got gnt %b, no grant required", gnt);
      end else begin
        ge = gq.pop_front();
        check("gnt_port", 32'(gnt), 32'(ge.gnt));
        check("gnt_wr_en", 32'(mem_wr_en), 32'(ge.we));
        check("gnt_rd_en", 32'(mem_rd_en), 32'(!ge.we));
        check("gnt_addr", 32'(mem_addr), 32'(ge.addr));
        if (ge.we) check("gnt_wdata", 32'(mem_wr_data), 32'(ge.wdata));
      end
      gnt_cycles.push_back(cyc);
    end
    if (rvalid != 2'b00) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got rvalid %b, no read data required", rvalid);
      end else begin
        re = rq.pop_front();
        check("rvalid_port", 32'(rvalid), 32'(re.port));
        check("rdata", 32'(rdata), 32'(re.data));
        check("rvalid_after_read_gnt", 32'({prev_gnt, prev_rd}), 32'({rvalid, 1'b1}));
      end
    end
    prev_gnt = gnt;
    prev_rd  = mem_rd_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req = '0; we = '0; lock = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Preload through port 1 writes.
    push_g(2'b10, 1'b1, 16'h0010, 8'hA5);
    push_g(2'b10, 1'b1, 16'h0000, 8'h11);
    push_g(2'b10, 1'b1, 16'h0001, 8'h22);
    push_g(2'b10, 1'b1, 16'h0040, 8'h3C);
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0000, 8'h11, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0001, 8'h22, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0040, 8'h3C, lat);
    reset_pulse();

    // Single read right after reset.
    push_g(2'b01, 1'b0, 16'h0010, 8'h00);
    push_r(2'b01, 8'hA5);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 8'h00, lat);
    check("single_read_gnt_latency", 32'(lat), 32'd2);

    // Write then read in the immediately following access.
    push_g(2'b10, 1'b1, 16'h1234, 8'h5A);
    push_g(2'b01, 1'b0, 16'h1234, 8'h00);
    push_r(2'b01, 8'h5A);
    issue(1'b1, 1'b1, 1'b0, 16'h1234, 8'h5A, lat);
    issue(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, lat);
    reset_pulse();

    // Contention: grants alternate starting with port 0.
    n0 = gnt_cycles.size();
    push_g(2'b01, 1'b0, 16'h0010, 8'h00); push_r(2'b01, 8'hA5);
    push_g(2'b10, 1'b0, 16'h0001, 8'h00); push_r(2'b10, 8'h22);
    push_g(2'b01, 1'b0, 16'h0000, 8'h00); push_r(2'b01, 8'h11);
    push_g(2'b10, 1'b0, 16'h1234, 8'h00); push_r(2'b10, 8'h5A);
    fork
      begin
        int l0;
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 8'h00, l0);
        issue(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, l0);
      end
      begin
        int l1;
        issue(1'b1, 1'b0, 1'b0, 16'h0001, 8'h00, l1);
        issue(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, l1);
      end
    join
    for (int i = 0; i < 3; i++)
      check("contention_gap", 32'(gnt_cycles[n0+i+1] - gnt_cycles[n0+i]), 32'd2);
    repeat (4) @(posedge clk); #1;

    // Lock: port 0 waits until port 1's unlocked write is granted.
    push_g(2'b10, 1'b0, 16'h0040, 8'h00); push_r(2'b10, 8'h3C);
    push_g(2'b10, 1'b1, 16'h0040, 8'h77);
    push_g(2'b01, 1'b0, 16'h0040, 8'h00); push_r(2'b01, 8'h77);
    fork
      begin
        int l1;
        issue(1'b1, 1'b0, 1'b1, 16'h0040, 8'h00, l1);
        repeat (3) @(posedge clk); #1;
        issue(1'b1, 1'b1, 1'b0, 16'h0040, 8'h77, l1);
      end
      begin
        int l0;
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 1'b0, 16'h0040, 8'h00, l0);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Reset during the ACCESS of a port 0 read.
    push_g(2'b01, 1'b0, 16'h0001, 8'h00);
    addr0 = 16'h0001; we[0] = 1'b0; lock[0] = 1'b0; req[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (gnt[0]) begin lat = i; break; end
    end
    check("rst_mid_gnt_seen", 32'(lat != 0), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_no_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    push_g(2'b01, 1'b0, 16'h0001, 8'h00);
    push_r(2'b01, 8'h22);
    issue(1'b0, 1'b0, 1'b0, 16'h0001, 8'h00, lat);
    check("rst_mid_next_gnt_latency", 32'(lat), 32'd2);
    repeat (3) @(posedge clk); #1;

    // Back-to-back reads from the same port with req held.
    n0 = gnt_cycles.size();
    push_g(2'b01, 1'b0, 16'h0000, 8'h00); push_r(2'b01, 8'h11);
    push_g(2'b01, 1'b0, 16'h0001, 8'h00); push_r(2'b01, 8'h22);
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, lat);
    issue(1'b0, 1'b0, 1'b0, 16'h0001, 8'h00, lat);
    repeat (4) @(negedge clk);
    check("b2b_grant_count", 32'(gnt_cycles.size() - n0), 32'd2);
    check("b2b_gap", 32'(gnt_cycles[n0+1] - gnt_cycles[n0]), 32'd2);

    check("grants_outstanding", 32'(gq.size()), 32'd0);
    check("reads_outstanding", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
